// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU into HI/LO, borrowing the EX-stage ALU for each add/subtract step
module mdu_sequencer #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF,
    parameter int          ITERS   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_aluop,
    input  logic [31:0] alu_result
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    localparam logic [4:0] LAST = 5'(ITERS - 1);
    state_t      state, state_nx;
    logic [1:0]  op_r;
    logic [31:0] rs_r, rt_r, mc, q, acc;
    logic [4:0]  cnt;
    logic        is_div, is_sgn, carry, ge, neg;
    logic [31:0] rs_mag, rt_mag, quo_f, rem_f;
    logic [32:0] shifted;
    logic [63:0] prod_f;
    assign is_div = op_r[1];
    assign is_sgn = op_r[0];
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_aluop = 2'b00;
        rs_mag    = (is_sgn && rs_r[31]) ? -rs_r : rs_r;
        rt_mag    = (is_sgn && rt_r[31]) ? -rt_r : rt_r;
        shifted   = {acc, q[31]};
        carry     = alu_result < acc;
        ge        = shifted[32] | (shifted[31:0] >= mc);
        neg       = is_sgn && (rs_r[31] ^ rt_r[31]);
        prod_f    = neg ? -{acc, q} : {acc, q};
        quo_f     = neg ? -q : q;
        rem_f     = (is_sgn && rs_r[31]) ? -acc : acc;
        case (state)
            IDLE: state_nx = (start && !cancel) ? PREP : IDLE;
            PREP: begin
                busy     = 1'b1;
                state_nx = cancel ? IDLE : (is_div && rt_r == '0) ? DONE : ITER;
            end
            ITER: begin
                busy      = 1'b1;
                alu_a     = is_div ? shifted[31:0] : acc;
                alu_b     = mc;
                alu_aluop = is_div ? 2'b01 : 2'b00;
                state_nx  = cancel ? IDLE : (cnt == LAST) ? FIX : ITER;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = cancel ? IDLE : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // mc holds the ALU-side operand (multiplicand or divisor); q shifts the multiplier or collects the quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= '0;
            rs_r        <= '0;
            rt_r        <= '0;
            mc          <= '0;
            q           <= '0;
            acc         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !cancel) begin
                    op_r        <= op;
                    rs_r        <= rs_val;
                    rt_r        <= rt_val;
                    div_by_zero <= 1'b0;
                end
                PREP: begin
                    acc <= '0;
                    cnt <= '0;
                    mc  <= is_div ? rt_mag : rs_mag;
                    q   <= is_div ? rs_mag : rt_mag;
                    if (!cancel && is_div && rt_r == '0) begin
                        hi          <= rs_r;
                        lo          <= DIV0_LO;
                        div_by_zero <= 1'b1;
                    end
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc <= ge ? alu_result : shifted[31:0];
                        q   <= {q[30:0], ge};
                    end else if (q[0]) begin
                        acc <= {carry, alu_result[31:1]};
                        q   <= {alu_result[0], q[31:1]};
                    end else begin
                        acc <= {1'b0, acc[31:1]};
                        q   <= {acc[0], q[31:1]};
                    end
                end
                FIX: if (!cancel) begin
                    hi <= is_div ? rem_f : prod_f[63:32];
                    lo <= is_div ? quo_f : prod_f[31:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized scoreboard bench for mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [1:0]  op = '0, alu_aluop;
    logic [31:0] rs_val = '0, rt_val = '0, hi, lo, alu_a, alu_b, alu_result;
    logic        busy, done, div_by_zero;

    typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz; int s; int lat;} exp_t;
    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [1:0]  cur_op = '0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .cancel(cancel), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop), .alu_result(alu_result)
    );

    // stand-in for the EX-stage ALU
    assign alu_result = (alu_aluop == 2'b01) ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sa, sb2, p, qq, rr;
        sa  = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb2 = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
        z   = 1'b0;
        if (!o[1]) begin
            p = sa * sb2;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
            z = 1'b1;
        end else begin
            qq = sa / sb2;
            rr = sa % sb2;
            h  = rr[31:0];
            l  = qq[31:0];
        end
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("latency", cyc - e.s + 1, e.lat);
            end
        end
        if (rst_n && !busy) chk("idle_alu", {alu_a, alu_b[29:0], alu_aluop}, 64'h0);
        if (rst_n && busy && !cur_op[1]) chk("mult_aluop", alu_aluop, 2'b00);
    end

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        cur_op = o;
        if (push) begin
            model(o, a, b, e.hi, e.lo, e.dbz);
            e.s   = cyc + 1;
            e.lat = (o[1] && b == 0) ? 2 : 35;
            m_hi  = e.hi;
            m_lo  = e.lo;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start_op(o, a, b, 1'b1);
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, div_by_zero, hi, lo}, 67'h0);
        rst_n = 1'b1;
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b01, 32'hFFFF_FFFD, 32'd7);
        run(2'b01, 32'h8000_0000, 32'h8000_0000);
        run(2'b10, 32'd100, 32'd7);
        run(2'b11, -32'sd7, 32'd2);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b11, 32'h1234, 32'h0);
        run(2'b10, 32'd9, 32'd3);
        // second start during a MULTU must be dropped
        start_op(2'b00, 32'h0001_2345, 32'h0000_ABCD, 1'b1);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        // cancel mid-iteration: no done, HI/LO keep prior values
        start_op(2'b01, 32'h7777_0000, 32'h0000_0003, 1'b0);
        repeat (8) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hilo", {hi, lo}, {m_hi, m_lo});
        chk("cancel_dbz", div_by_zero, 0);
        repeat (40) @(negedge clk);
        // cancel together with start in IDLE
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        chk("cancel_start", busy, 0);
        // async reset mid-divide
        start_op(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_alu", {alu_aluop, alu_a}, 34'h0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(2'b10, 32'd100, 32'd7);
        for (int i = 0; i < 40; i++) run(2'($urandom_range(0, 3)), pick(), pick());
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit for the EX stage, implementing MULT, MULTU, DIV and DIVU into HI/LO.
- Produces no arithmetic of its own beyond sign fix-up, carry/borrow detect and shifts.
- Each iteration's 32-bit add or subtract is driven through the existing ALU: an ALUOp of 00 selects add, 01 selects subtract.
- Sits beside the EX stage; the EX mux hands the ALU operands to this block while busy is high.

Parameters:
- DIV0_LO, 32'hFFFF_FFFF: LO value written on divide-by-zero.
- ITERS, 32: iteration count. Fixed for 32-bit operands; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_val  input  32  multiplicand / dividend.
- rt_val  input  32  multiplier / divisor.
- cancel  input  1  synchronous abort (pipeline flush).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  sticky until next accepted start.
- hi  output  32  HI register.
- lo  output  32  LO register.
- alu_a  output  32  to ALU operando_1.
- alu_b  output  32  to ALU operando_2.
- alu_aluop  output  2  to ALU ALUOp.
- alu_result  input  32  from ALU result.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, div_by_zero=0; hi=lo=0; alu_a=alu_b=0; alu_aluop=00; all internal registers 0. Reset asserted mid-operation aborts immediately, with no done.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: on start=1, latch op, rs_val and rt_val, clear div_by_zero, go to PREP. busy rises the next cycle.
- PREP (1 cycle):
  - Signed ops: replace each operand with its magnitude and record the sign of each.
  - Unsigned ops: pass operands through unchanged.
  - Clear the accumulator, load the 5-bit iteration counter with 0.
  - If the op is a divide and the divisor is 0: set hi=rs_val (raw), lo=DIV0_LO, div_by_zero=1, go directly to DONE.
- ITER (exactly ITERS cycles, counter 0..31), multiply (shift-add):
  - alu_a = acc_hi, alu_b = multiplicand magnitude, alu_aluop = 00.
  - carry = (alu_result < alu_a), unsigned.
  - If mplier[0]=1: {acc_hi, mplier} <= {carry, alu_result, mplier[31:1]}. Otherwise {acc_hi, mplier} <= {1'b0, acc_hi, mplier[31:1]}.
- ITER, divide (restoring):
  - shifted = {rem, quo[31]} (33 bits).
  - alu_a = shifted[31:0], alu_b = divisor magnitude, alu_aluop = 01.
  - ge = shifted[32] | (shifted[31:0] >= divisor).
  - rem <= ge ? alu_result : shifted[31:0].
  - quo <= {quo[30:0], ge}.
- FIX (1 cycle):
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: hi = product[63:32] or remainder; lo = product[31:0] or quotient.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start arriving in DONE is ignored.
- Latency:
  - start sampled at edge 0; busy=1 during cycles 1..34; done=1 in cycle 35.
  - Divide-by-zero: done=1 in cycle 2.
- Outside ITER: alu_aluop=00 and alu_a=alu_b=0.
- start while busy: ignored, with no queuing.
- cancel=1 in PREP, ITER or FIX: go to IDLE next edge; no done; hi, lo and div_by_zero unchanged from their pre-start values, except that div_by_zero was already cleared at acceptance.
- cancel in IDLE: no effect. cancel together with start in IDLE: start is ignored.
- hi/lo hold their values between completed operations.
- 0x80000000 / 0xFFFFFFFF signed: the magnitude 2^31 fits in 32 bits, giving lo=0x80000000, hi=0, with no trap.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done in cycle 35; hi=0xFFFFFFFE, lo=0x00000001; alu_aluop=00 throughout ITER.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV rs=0x1234, rt=0 -> done in cycle 2; div_by_zero=1; hi=0x1234, lo=0xFFFFFFFF. A subsequent DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
- start pulsed again at cycle 5 of a MULTU -> ignored; a single done at cycle 35. cancel at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep their prior values.
- rst_n driven low at cycle 20 of a DIV -> immediately busy=0, hi=lo=0, alu_aluop=00. A new DIVU 100/7 after release completes correctly.
